// File: rtl/alice_tx_feeder.sv
// Alice TX feeder: 128-bit block FIFO, session request FSM, one block in flight; data_stb 1 cycle after issue condition.
// Backpressure: usr_ready low when FIFO full; issue waits on ready and on o_stb for the previous block. Option: ALICE_TX_FEEDER_REQ_TIMEOUT_EN.
module alice_tx_feeder #(
   parameter int FIFO_AW     = 3,
   parameter int REQ_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [127:0]       usr_data,
   input  logic               usr_valid,
   output logic               usr_ready,
   output logic [FIFO_AW:0]   fill_level,
   output logic               transmit_req,
   input  logic               ready_for_transmit,
   input  logic               ready,
   output logic [127:0]       data_in,
   output logic               data_stb,
   input  logic               o_stb,
   output logic               busy,
   output logic               ack_err,
   output logic               req_timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQUEST = 2'd1,
      S_STREAM  = 2'd2
   } state_t;

   state_t           r_state;
   logic [FIFO_AW:0] r_wptr;
   logic [FIFO_AW:0] r_rptr;
   logic [127:0]     r_mem [2**FIFO_AW];
   logic [127:0]     r_data;
   logic             r_treq;
   logic             r_stb;
   logic             r_out;
   logic             r_ack_err;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_issue;
   logic             w_tmo;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                    (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
   assign w_push  = usr_valid && !w_full;
   // A high ready_for_transmit in STREAM means the session is ending, so never issue then.
   assign w_issue = (r_state == S_STREAM) && ready && !r_out && !w_empty && !ready_for_transmit;

   assign usr_ready    = !w_full;
   assign fill_level   = r_wptr - r_rptr;
   assign transmit_req = r_treq;
   assign data_in      = r_data;
   assign data_stb     = r_stb;
   assign ack_err      = r_ack_err;
   assign busy         = (r_state != S_IDLE) || !w_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= usr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push)  r_wptr <= r_wptr + 1'b1;
         if (w_issue) r_rptr <= r_rptr + 1'b1;
      end
   end

`ifdef ALICE_TX_FEEDER_REQ_TIMEOUT_EN
   localparam int TW = $clog2(REQ_TIMEOUT + 1);
   logic [TW-1:0] r_tcnt;
   logic          r_tmo;

   assign w_tmo       = (r_state == S_REQUEST) && ready_for_transmit &&
                        (r_tcnt == TW'(REQ_TIMEOUT - 1));
   assign req_timeout = r_tmo;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tcnt <= '0;
         r_tmo  <= 1'b0;
      end else begin
         r_tmo <= w_tmo;
         if (r_state == S_REQUEST && !w_tmo) r_tcnt <= r_tcnt + 1'b1;
         else                                r_tcnt <= '0;
      end
   end
`else
   logic w_unused_param;
   assign w_unused_param = (REQ_TIMEOUT == 0);
   assign w_tmo          = 1'b0;
   assign req_timeout    = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_treq    <= 1'b0;
         r_stb     <= 1'b0;
         r_out     <= 1'b0;
         r_ack_err <= 1'b0;
         r_data    <= '0;
      end else begin
         r_treq    <= (r_state == S_REQUEST);
         r_stb     <= w_issue;
         r_ack_err <= o_stb && !r_out;
         if (w_issue) r_data <= r_mem[r_rptr[FIFO_AW-1:0]];
         if (w_issue)    r_out <= 1'b1;
         else if (o_stb) r_out <= 1'b0;
         case (r_state)
            S_IDLE:
               if (!w_empty && ready_for_transmit) r_state <= S_REQUEST;
            S_REQUEST:
               if (!ready_for_transmit) r_state <= S_STREAM;
               else if (w_tmo)          r_state <= S_IDLE;
            S_STREAM:
               // The in-flight block, acknowledged or not, is dropped with the session.
               if (ready_for_transmit) begin
                  r_state <= S_IDLE;
                  r_out   <= 1'b0;
               end
            default:
               r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alice_tx_feeder.sv
// Bench for alice_tx_feeder: directed steps plus a randomized streaming phase against a queue-based model.
module tb_alice_tx_feeder;
   localparam int AW   = 3;
   localparam int TMO  = 16;
   localparam int DEPTH = 2**AW;

   logic           clk = 1'b0;
   logic           reset;
   logic [127:0]   usr_data;
   logic           usr_valid;
   logic           usr_ready;
   logic [AW:0]    fill_level;
   logic           transmit_req;
   logic           ready_for_transmit;
   logic           ready;
   logic [127:0]   data_in;
   logic           data_stb;
   logic           o_stb;
   logic           busy;
   logic           ack_err;
   logic           req_timeout;

   int tests = 0;
   int fails = 0;

   // Model: blocks held in the FIFO in push order, plus "a strobed block awaits o_stb".
   logic [127:0] exp_q[$];
   logic         m_out = 1'b0;

   alice_tx_feeder #(.FIFO_AW(AW), .REQ_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .usr_data(usr_data), .usr_valid(usr_valid), .usr_ready(usr_ready),
      .fill_level(fill_level), .transmit_req(transmit_req),
      .ready_for_transmit(ready_for_transmit), .ready(ready),
      .data_in(data_in), .data_stb(data_stb), .o_stb(o_stb),
      .busy(busy), .ack_err(ack_err), .req_timeout(req_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock; inputs set before the call are sampled at this edge, outputs checked #1 after it.
   task automatic tick();
      logic         acc;
      logic         stb_ok;
      logic         pre_ack;
      logic         pre_rft;
      logic         exp_ack;
      logic [127:0] d;
      acc     = usr_valid && (exp_q.size() < DEPTH);
      d       = usr_data;
      stb_ok  = ready && !ready_for_transmit && !m_out && (exp_q.size() != 0);
      pre_ack = o_stb;
      pre_rft = ready_for_transmit;
      exp_ack = o_stb && !m_out;
      @(posedge clk);
      #1;
      chk("ack_err", ack_err, exp_ack);
      if (data_stb) begin
         chk("stb_allowed", stb_ok, 1);
         if (exp_q.size() != 0) begin
            chk("stb_order", data_in, exp_q[0]);
            void'(exp_q.pop_front());
         end
         m_out = 1'b1;
      end else if (pre_ack || pre_rft) begin
         m_out = 1'b0;
      end
      if (acc) exp_q.push_back(d);
      chk("fill_level", fill_level, exp_q.size());
      chk("usr_ready", usr_ready, exp_q.size() < DEPTH);
   endtask

   task automatic wait_stb(input string tag, input int budget);
      int k;
      k = 1;
      tick();
      while (!data_stb && k < budget) begin
         tick();
         k++;
      end
      chk(tag, data_stb, 1);
   endtask

   initial begin
      logic [127:0] blk11;
      logic [127:0] blk_a;
      logic [127:0] blk_b;
      logic [127:0] blk_c;
      int k;

      blk11 = {16{8'h11}};
      reset = 1'b0;
      usr_data = '0;
      usr_valid = 1'b0;
      ready_for_transmit = 1'b0;
      ready = 1'b0;
      o_stb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_usr_ready", usr_ready, 1);
      chk("rst_fill", fill_level, 0);
      chk("rst_treq", transmit_req, 0);
      chk("rst_data_in", data_in, 0);
      chk("rst_data_stb", data_stb, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack_err", ack_err, 0);
      chk("rst_req_timeout", req_timeout, 0);
      reset = 1'b1;

      // Single block: request two cycles after push, one strobe once streaming.
      ready_for_transmit = 1'b1;
      tick();
      usr_data = blk11;
      usr_valid = 1'b1;
      tick();
      usr_valid = 1'b0;
      chk("t1_treq_n0", transmit_req, 0);
      tick();
      chk("t1_treq_n1", transmit_req, 0);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_treq_rise", transmit_req, 1);
      ready_for_transmit = 1'b0;
      ready = 1'b1;
      tick();
      chk("t1_treq_hold", transmit_req, 1);
      tick();
      chk("t1_stb", data_stb, 1);
      chk("t1_data", data_in, blk11);
      chk("t1_treq_fall", transmit_req, 0);
      tick();
      chk("t1_stb_once", data_stb, 0);
      o_stb = 1'b1;
      tick();
      o_stb = 1'b0;

      // Three blocks in one session, each released only after the previous ack.
      blk_a = rnd128();
      blk_b = rnd128();
      blk_c = rnd128();
      usr_valid = 1'b1;
      usr_data = blk_a;
      tick();
      usr_data = blk_b;
      tick();
      chk("t2_stb_a", data_stb, 1);
      chk("t2_data_a", data_in, blk_a);
      usr_data = blk_c;
      tick();
      usr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_hold_b", data_stb, 0);
      end
      o_stb = 1'b1;
      tick();
      o_stb = 1'b0;
      chk("t2_gap_b", data_stb, 0);
      tick();
      chk("t2_stb_b", data_stb, 1);
      chk("t2_data_b", data_in, blk_b);
      o_stb = 1'b1;
      tick();
      o_stb = 1'b0;
      chk("t2_gap_c", data_stb, 0);
      tick();
      chk("t2_stb_c", data_stb, 1);
      chk("t2_data_c", data_in, blk_c);
      o_stb = 1'b1;
      tick();
      o_stb = 1'b0;

      // Leave the session, then overfill with no session running.
      ready_for_transmit = 1'b1;
      tick();
      ready_for_transmit = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         usr_valid = 1'b1;
         usr_data = rnd128();
         tick();
      end
      usr_valid = 1'b0;
      chk("t3_fill_full", fill_level, DEPTH);
      chk("t3_usr_ready_low", usr_ready, 0);
      chk("t3_no_stb", data_stb, 0);

      // New session; random push/pop traffic crosses the pointer wrap.
      ready_for_transmit = 1'b1;
      tick();
      ready_for_transmit = 1'b0;
      tick();
      for (int i = 0; i < 400; i++) begin
         usr_valid = ($urandom_range(0, 9) < 7);
         usr_data = rnd128();
         ready = ($urandom_range(0, 3) != 0);
         o_stb = m_out && ($urandom_range(0, 2) == 0);
         tick();
      end
      usr_valid = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 300 && (exp_q.size() != 0 || m_out); i++) begin
         o_stb = m_out;
         tick();
      end
      o_stb = 1'b0;
      chk("t3_drained", fill_level, 0);

      // Stray acknowledge while idle.
      ready_for_transmit = 1'b1;
      tick();
      chk("t4_busy_idle", busy, 0);
      o_stb = 1'b1;
      tick();
      o_stb = 1'b0;
      chk("t4_ack_err", ack_err, 1);
      chk("t4_no_stb", data_stb, 0);
      chk("t4_treq", transmit_req, 0);
      tick();
      chk("t4_ack_err_clr", ack_err, 0);
      chk("t4_still_idle", busy, 0);

      // Session ends mid-stream with two blocks queued; they go out in the next session.
      for (int i = 0; i < 3; i++) begin
         usr_valid = 1'b1;
         usr_data = rnd128();
         tick();
      end
      usr_valid = 1'b0;
      ready_for_transmit = 1'b0;
      wait_stb("t5_stb_d", 10);
      ready_for_transmit = 1'b1;
      tick();
      chk("t5_busy", busy, 1);
      k = 0;
      while (!transmit_req && k < 5) begin
         tick();
         k++;
      end
      chk("t5_treq_again", transmit_req, 1);
      ready_for_transmit = 1'b0;
      wait_stb("t5_stb_e", 10);
      o_stb = 1'b1;
      tick();
      o_stb = 1'b0;
      wait_stb("t5_stb_f", 10);
      o_stb = 1'b1;
      tick();
      o_stb = 1'b0;

      // Asynchronous reset while a strobe is on the outputs.
      usr_valid = 1'b1;
      usr_data = rnd128();
      tick();
      usr_data = rnd128();
      tick();
      usr_valid = 1'b0;
      chk("t5_stb_g", data_stb, 1);
      reset = 1'b0;
      #1;
      chk("t5_rst_stb", data_stb, 0);
      chk("t5_rst_data", data_in, 0);
      chk("t5_rst_fill", fill_level, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_usr_ready", usr_ready, 1);
      chk("t5_rst_treq", transmit_req, 0);
      exp_q.delete();
      m_out = 1'b0;
      ready_for_transmit = 1'b1;
      ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Request held with ready_for_transmit stuck high.
      usr_valid = 1'b1;
      usr_data = rnd128();
      tick();
      usr_valid = 1'b0;
      tick();
      chk("t6_treq_entry", transmit_req, 0);
      for (int i = 1; i <= 20; i++) begin
         tick();
`ifdef ALICE_TX_FEEDER_REQ_TIMEOUT_EN
         chk($sformatf("t6_tmo_%0d", i), req_timeout, i == TMO);
         chk($sformatf("t6_treq_%0d", i), transmit_req, i != TMO + 1);
`else
         chk($sformatf("t6_tmo_%0d", i), req_timeout, 0);
         chk($sformatf("t6_treq_%0d", i), transmit_req, 1);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
